// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, ID-stage branch
// flushes, data-memory wait freezes with timeout flag, and debug halt.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch_taken,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             err_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              mem_err_q, mem_err_d;
    logic              load_use;
    logic              resolve;

    // A load into r0 never produces a value worth waiting for.
    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_flush     = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_write = 1'b1;
        halted       = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        resolve      = 1'b0;

        case (state_q)
            S_RUN: begin
                if (mem_req && !mem_ready) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    state_d      = S_MEM_WAIT;
                    wait_cnt_d   = WAIT_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!mem_ready) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    resolve    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_HALT: begin
                halted       = 1'b1;
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                ex_mem_write = 1'b0;
                if (!halt_req) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = '0;
            end
        endcase

        // Shared by a plain RUN cycle and the cycle a memory wait completes.
        if (resolve) begin
            if (halt_req) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                ex_mem_write = 1'b0;
                state_d      = S_HALT;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (id_branch_taken) begin
                if_flush = 1'b1;
            end
        end

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_flush     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_write = 1'b0;
            halted       = 1'b0;
        end
    end

    // Timeout is re-asserted every cycle the wait sits at the limit, so a clear
    // only sticks once the access has finally completed.
    always_comb begin
        mem_err_d = mem_err_q;
        if (wait_cnt_d == WAIT_MAX) begin
            mem_err_d = 1'b1;
        end else if (err_clr) begin
            mem_err_d = 1'b0;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_write && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl: each row is one cycle of inputs and the
// outputs expected during that cycle; expectations pass through a scoreboard queue.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    // {pc_write, if_id_write, if_flush, id_ex_bubble, ex_mem_write}
    localparam logic [4:0] ADV = 5'b11001;
    localparam logic [4:0] FRZ = 5'b00000;
    localparam logic [4:0] LU  = 5'b00011;
    localparam logic [4:0] BR  = 5'b11101;
    localparam logic [4:0] RST = 5'b00110;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic       br;
        logic       emr;
        logic [4:0] ert;
        logic       mreq;
        logic       mrdy;
        logic       halt;
        logic       clr;
        logic [4:0] en;
        logic       hl;
        logic       me;
    } vec_t;

    typedef struct {
        logic [4:0]       en;
        logic             hl;
        logic             me;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, id_branch_taken, ex_mem_read;
    logic             mem_req, mem_ready, halt_req, err_clr;
    logic             pc_write, if_id_write, if_flush, id_ex_bubble, ex_mem_write;
    logic             halted, mem_err;
    logic [CNT_W-1:0] stall_cycles;

    int   checks   = 0;
    int   failures = 0;
    int   exp_stall = 0;
    vec_t vecs[$];
    exp_t sb[$];

    pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .err_clr(err_clr),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
        .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                                input logic br, input logic emr, input logic [4:0] ert,
                                input logic mreq, input logic mrdy, input logic halt,
                                input logic clr, input logic [4:0] en, input logic hl,
                                input logic me);
        vec_t v;
        v.rs = rs; v.rt = rt; v.ut = ut; v.br = br; v.emr = emr; v.ert = ert;
        v.mreq = mreq; v.mrdy = mrdy; v.halt = halt; v.clr = clr;
        v.en = en; v.hl = hl; v.me = me;
        return v;
    endfunction

    function automatic logic [4:0] en_now();
        return {pc_write, if_id_write, if_flush, id_ex_bubble, ex_mem_write};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.ut; id_branch_taken = v.br;
        ex_mem_read = v.emr; ex_rt = v.ert; mem_req = v.mreq; mem_ready = v.mrdy;
        halt_req = v.halt; err_clr = v.clr;
        e.en = v.en; e.hl = v.hl; e.me = v.me; e.sc = CNT_W'(exp_stall);
        sb.push_back(e);
        if (v.en[4] == 1'b0) exp_stall++;
    endtask

    task automatic compare_row(input int idx);
        exp_t e;
        e = sb.pop_front();
        $display("row %0d: en=%b halted=%b mem_err=%b stall=%0d", idx, en_now(), halted,
                 mem_err, stall_cycles);
        check($sformatf("row%0d_enables", idx), 32'(en_now()), 32'(e.en));
        check($sformatf("row%0d_halted", idx), 32'(halted), 32'(e.hl));
        check($sformatf("row%0d_mem_err", idx), 32'(mem_err), 32'(e.me));
        check($sformatf("row%0d_stall_cycles", idx), 32'(stall_cycles), 32'(e.sc));
    endtask

    initial begin
        //            rs rt ut br emr ert mreq mrdy halt clr en   hl me
        vecs.push_back(mk(8, 0, 0, 0, 1, 8, 0, 0, 0, 0, LU,  0, 0)); // load-use on rs
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 0));
        vecs.push_back(mk(0, 8, 0, 0, 1, 8, 0, 0, 0, 0, ADV, 0, 0)); // rt not a source
        vecs.push_back(mk(0, 8, 1, 0, 1, 8, 0, 0, 0, 0, LU,  0, 0)); // rt is a source
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, ADV, 0, 0)); // r0 never hazards
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, BR,  0, 0)); // taken branch
        vecs.push_back(mk(8, 0, 0, 1, 1, 8, 0, 0, 0, 0, LU,  0, 0)); // hazard beats flush
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 0)); // 3-cycle mem wait
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, ADV, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 0)); // timeout run
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, FRZ, 0, 1)); // clr loses to set
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, ADV, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ADV, 0, 1)); // clr after completion
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, ADV, 0, 0)); // zero-wait access
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, FRZ, 0, 0)); // mem wait beats halt
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, ADV, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, BR,  0, 0)); // branch on completion
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 0, 0)); // halt deferred
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, FRZ, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, FRZ, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, FRZ, 1, 0)); // mem_req ignored
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 1, 0)); // release cycle
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 0));
        vecs.push_back(mk(8, 0, 0, 0, 1, 8, 0, 0, 1, 0, FRZ, 0, 0)); // halt beats hazard
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0));

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0));
        exp_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        compare_row(-1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #4;
            compare_row(i);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while halted: takes effect without a clock edge.
        #2;
        check("pre_reset_halted", 32'(halted), 32'd1);
        rst = 1'b1;
        #1;
        $display("async reset: halted=%b stall=%0d en=%b", halted, stall_cycles, en_now());
        check("async_rst_halted", 32'(halted), 32'd0);
        check("async_rst_stall", 32'(stall_cycles), 32'd0);
        check("async_rst_enables", 32'(en_now()), 32'(RST));
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stall = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 0));
        #4;
        compare_row(99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
